// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave memory block.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned APB_ADDR_W = 9;
  localparam int unsigned APB_DATA_W = 8;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

endpackage

// File: rtl/apb_slv_regfile.sv
// MEM_DEPTH x DATA_WIDTH register file: async clear, synchronous write,
// combinational read. Out-of-range indices read as zero and never write.
module apb_slv_regfile #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [7:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [7:0]            rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned IW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [8:0]  DEPTH9 = 9'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = ({1'b0, wr_idx} < DEPTH9);
  assign rd_ok = ({1'b0, rd_idx} < DEPTH9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we && wr_ok) begin
      mem[wr_idx[IW-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_ok ? mem[rd_idx[IW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with register-file memory and programmable wait states.
// Optional write protection of indices >= RO_BASE via APB_SLV_WRPROT_EN.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH  = APB_DATA_W,
  parameter int unsigned MEM_DEPTH   = 128,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  RO_BASE     = 8'h60
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned CW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [8:0]  DEPTH9 = 9'(MEM_DEPTH);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [7:0]            idx;
  logic                  addr_err;
  logic                  prot_err;
  logic                  err;
  logic                  ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // PADDR[8] and above are decoded upstream into PSEL.
  assign idx      = PADDR[7:0];
  assign addr_err = ({1'b0, idx} >= DEPTH9);

`ifdef APB_SLV_WRPROT_EN
  assign prot_err = PWRITE && !addr_err && (idx >= RO_BASE);
`else
  logic unused;
  assign unused   = &{1'b0, RO_BASE};
  assign prot_err = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, PADDR[ADDR_WIDTH-1:8]};

  assign err   = addr_err || prot_err;
  assign ready = (state == ACCESS) && PSEL && PENABLE && (cnt == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt = ACCESS;
          cnt_nxt   = CW'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          if (cnt != '0) cnt_nxt = cnt - CW'(1);
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_we = ready && PWRITE && !err;

  apb_slv_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_regfile (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we      (mem_we),
    .wr_idx  (idx),
    .wr_data (PWDATA),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  assign PREADY  = ready;
  assign PSLVERR = (ready && err) ? RESP_ERR : RESP_OK;
  assign PRDATA  = (ready && !PWRITE && !addr_err) ? rd_data : '0;

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB slave with a parameterised register-file memory and programmable wait states. It sits directly downstream of the APB master bridge: one instance on PSEL1 and one on PSEL2. It consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PREADY/PRDATA/PSLVERR. Out-of-range accesses complete with an error response instead of hanging the bus.

Parameters:
ADDR_WIDTH, 9, bus address width; only PADDR[7:0] indexes memory, PADDR[8] ignored (decoded upstream into PSEL).
DATA_WIDTH, 8, data width.
MEM_DEPTH, 128, number of words; legal index 0..MEM_DEPTH-1, max 256.
WAIT_STATES, 2, PENABLE cycles with PREADY=0 before completion; 0 means zero-wait.
RO_BASE, 8'h60, first read-only index (used only with the optional feature).

Ports:
PCLK  in  1  clock, rising edge.
PRESETn  in  1  reset, asynchronous assert, active-low.
PSEL  in  1  slave select from the bridge.
PENABLE  in  1  access phase.
PADDR  in  ADDR_WIDTH  address.
PWRITE  in  1  1=write, 0=read.
PWDATA  in  DATA_WIDTH  write data.
PREADY  out  1  transfer completion.
PRDATA  out  DATA_WIDTH  read data, valid only when PREADY=1 and PWRITE=0.
PSLVERR  out  1  error, valid only when PREADY=1.

Behaviour:
- Reset (PRESETn=0, async): state=IDLE, wait counter=0, all memory words=0. PREADY=0, PRDATA=0, PSLVERR=0. Reset mid-transfer aborts it: no write commits, and the master sees PREADY=0.
- FSM states IDLE and ACCESS.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup cycle); counter loads WAIT_STATES. In IDLE, PENABLE=1 without a preceding setup is ignored.
- ACCESS, PSEL=0: return to IDLE, no write, no response (master abort).
- ACCESS, PSEL=1, PENABLE=1, counter!=0: counter decrements; PREADY=0.
- PREADY = (state==ACCESS) & PSEL & PENABLE & (counter==0). This is combinational from registered state, so completion occurs exactly WAIT_STATES+1 PENABLE cycles after setup.
- Completion edge (PSEL & PENABLE & PREADY): state -> IDLE.
  - A legal write commits mem[PADDR[7:0]] <= PWDATA on this edge.
  - A read drives PRDATA=mem[PADDR[7:0]] during the PREADY cycle, using combinational read.
- Back-to-back transfers: PSEL held high with PENABLE=0 in the cycle after completion re-enters ACCESS. No idle cycle is required.
- addr_err = PADDR[7:0] >= MEM_DEPTH. PSLVERR = PREADY & addr_err. An erroring write does not modify memory. An erroring read returns PRDATA=0.
- PRDATA=0 whenever PREADY=0 or PWRITE=1.
- PADDR/PWRITE/PWDATA are sampled at the completion edge. They are required stable from setup, but stability is not checked.

Optional Feature:
APB_SLV_WRPROT_EN:
- Defined: indices >= RO_BASE (and < MEM_DEPTH) are read-only. A write there completes with PSLVERR=1 and memory is unchanged. Reads are normal.
- Undefined: RO_BASE is unused and all in-range indices are writable.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, ACCESS};
  - default width constants APB_ADDR_W=9 and APB_DATA_W=8;
  - response localparams RESP_OK/RESP_ERR.
- One sub-module, apb_slv_regfile: MEM_DEPTH x DATA_WIDTH array with async clear, synchronous write enable, and combinational read port. Address decode, error logic, and the FSM/counter stay in apb_slave_mem.

Test Plan:
- Reset, then write 0x05<-0xA5 and read 0x05 with WAIT_STATES=2:
  - PREADY rises on the 3rd PENABLE cycle of each transfer;
  - read returns PRDATA=0xA5 with PSLVERR=0.
- Instance with WAIT_STATES=0, back-to-back writes 0x10<-0x11 and 0x11<-0x22 with PSEL held high, then reads:
  - PREADY=1 in the first PENABLE cycle of each transfer;
  - reads return 0x11 and 0x22.
- Write 0x90<-0x33 (MEM_DEPTH=128):
  - PREADY=1 and PSLVERR=1;
  - a subsequent read of 0x90 returns PSLVERR=1 and PRDATA=0;
  - a read of 0x10 (=0x11 from the previous test) is unchanged.
- Write 0x20<-0x77, with PRESETn pulsed low during the 2nd PENABLE cycle:
  - PREADY stays 0;
  - after reset, a read of 0x20 returns 0x00.
- PSEL dropped in ACCESS before PREADY on a write 0x30<-0x44:
  - FSM returns to IDLE and no PREADY pulse occurs;
  - a read of 0x30 returns 0x00.
- With APB_SLV_WRPROT_EN, write 0x60<-0x55:
  - PSLVERR=1 and a read returns 0x00;
  - without the macro, the same write gives PSLVERR=0 and a read returns 0x55.
